game_control: RTL and testbench
===============================

Name: game_control

Overview:
- Game-flow controller at the other end of the collision detector's resetn/go handshake.
- Consumes the detector's active-low collision flag (hit_n) and the player's y position.
- Tracks lives and score, sequences start, respawn and game-over, and drives go to re-arm the detector after every hit and every new game.
- Sits between the detector, the dot (player) mover, the lane movers (via run) and the score display.

Parameters:
- LIVES, 3: lives at game start; range 1..7.
- RESPAWN_CYCLES, 50000000: freeze length after a hit, in CLK cycles; minimum 1.
- WIN_Y, 0: y_dot at or below this value counts as a completed crossing.

Ports:
- CLK  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start_key  input  1  start button level, already synchronised, 1 = pressed.
- hit_n  input  1  collision flag from the detector, 0 = collision latched.
- y_dot  input  7  current player row.
- go  output  1  re-arm request to the detector; held high until hit_n returns to 1.
- run  output  1  1 = lanes and player may move.
- dot_respawn  output  1  one-cycle pulse; player mover returns the dot to its start row.
- lives  output  3  remaining lives.
- score  output  8  completed crossings, saturating.
- game_over  output  1  1 while in GAMEOVER.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-high.
  - Reset at any time, including mid-respawn: state = IDLE, go = 0, run = 0, dot_respawn = 0, lives = LIVES, score = 0, game_over = 0, respawn counter = 0, start_prev = 0, top_prev = 1.
- Edge detect: start_edge = start_key & ~start_prev. start_prev is registered every cycle.
- States: IDLE, ARM, PLAY, HIT, RESPAWN, GAMEOVER.
- Output decode from the state register:
  - go = (state == ARM).
  - run = (state == PLAY).
  - game_over = (state == GAMEOVER).
- dot_respawn is a registered pulse. It is high in the cycle after each event that requests it.
- IDLE:
  - On start_edge: go to ARM, load lives = LIVES, clear score, pulse dot_respawn.
- ARM:
  - go stays high.
  - When hit_n == 1 is sampled: go to PLAY. go therefore falls the cycle after hit_n is seen high.
  - No timeout; ARM holds indefinitely while hit_n = 0.
- PLAY:
  - If hit_n == 0: go to HIT and decrement lives (registered, same edge).
  - Else, on a crossing: score + 1 (saturating at 255), pulse dot_respawn, stay in PLAY.
    - Crossing = y_dot <= WIN_Y && !top_prev.
  - A collision takes priority over a crossing in the same cycle; no score is awarded.
  - top_prev = (y_dot <= WIN_Y), registered every cycle in every state. A dot parked at the top scores only once.
  - start_edge is ignored.
- HIT (exactly one cycle):
  - If lives == 0: go to GAMEOVER.
  - Otherwise: go to RESPAWN with counter = RESPAWN_CYCLES - 1.
- RESPAWN:
  - Counter decrements each cycle.
  - On the edge where counter == 0: go to ARM and pulse dot_respawn.
  - RESPAWN therefore lasts exactly RESPAWN_CYCLES cycles.
  - hit_n and start_key are ignored.
- GAMEOVER:
  - lives = 0; score is held for display.
  - On start_edge: go to ARM, lives = LIVES, score = 0, pulse dot_respawn.
- lives never underflows: a decrement happens only in the PLAY→HIT transition, and lives is at least 1 in PLAY.
- Key held through reset release: start_prev resets to 0, so a key held across reset release produces start_edge on the first clock after reset.

Test Plan (LIVES = 2, RESPAWN_CYCLES = 4, WIN_Y = 0):
- Reset and start:
  - Stimulus: reset pulse, then start_key 0→1 with hit_n = 1.
  - Response: IDLE with lives = 2, score = 0. Then ARM (go = 1) for 1 cycle with dot_respawn pulse. Then PLAY with run = 1.
- Collision and respawn:
  - Stimulus: in PLAY, hit_n = 0.
  - Response: HIT next edge with lives = 1. Then exactly 4 RESPAWN cycles with run = 0. Then ARM with go = 1 and dot_respawn pulse.
  - Continue: hold hit_n = 0 for 3 cycles in ARM, then release to 1. go stays high throughout and falls one cycle after hit_n rises; state goes to PLAY.
- Last life:
  - Stimulus: second collision in PLAY.
  - Response: lives = 0, HIT, then GAMEOVER with game_over = 1, run = 0, go = 0, score held.
  - Continue: start_edge → ARM with lives = 2, score = 0.
- Scoring:
  - Stimulus: y_dot 5→0 and held at 0 for 10 cycles.
  - Response: score increments once (0→1) with a single dot_respawn pulse.
  - Continue: y_dot 5→0 with hit_n = 0 in the same cycle → HIT, score stays 1.
- Saturation:
  - Stimulus: force 256 crossings.
  - Response: score holds at 255.
- Async reset mid-operation:
  - Stimulus: assert reset during RESPAWN with counter = 2, no clock edge.
  - Response: go = 0, run = 0, lives = 2 immediately; state = IDLE.

Source files
------------

// File: rtl/game_control.sv
// Game-flow controller: sequences start, play, hit, respawn and game-over,
// tracks lives and a saturating score, and re-arms the collision detector via go.
module game_control #(
    parameter int         LIVES          = 3,
    parameter int         RESPAWN_CYCLES = 50000000,
    parameter logic [6:0] WIN_Y          = 7'd0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start_key,
    input  logic       i_hit_n,
    input  logic [6:0] i_y_dot,
    output logic       o_go,
    output logic       o_run,
    output logic       o_dot_respawn,
    output logic [2:0] o_lives,
    output logic [7:0] o_score,
    output logic       o_game_over
);

    localparam int CW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD   = CW'(RESPAWN_CYCLES - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_HIT      = 3'd3;
    localparam logic [2:0] S_RESPAWN  = 3'd4;
    localparam logic [2:0] S_GAMEOVER = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    r_lives;
    logic [7:0]    r_score;
    logic [CW-1:0] r_cnt;
    logic          r_start_prev;
    logic          r_top_prev;
    logic          r_dot_respawn;

    logic w_start_edge;
    logic w_at_top;
    logic w_crossing;

    assign w_start_edge = i_start_key & ~r_start_prev;
    assign w_at_top     = (i_y_dot <= WIN_Y);
    // A dot parked at the top row scores only on arrival, not every cycle.
    assign w_crossing   = w_at_top & ~r_top_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_lives       <= LIVES_INIT;
            r_score       <= 8'd0;
            r_cnt         <= '0;
            r_start_prev  <= 1'b0;
            r_top_prev    <= 1'b1;
            r_dot_respawn <= 1'b0;
        end else begin
            r_start_prev  <= i_start_key;
            r_top_prev    <= w_at_top;
            r_dot_respawn <= 1'b0;
            case (r_state)
                S_IDLE, S_GAMEOVER: begin
                    if (w_start_edge) begin
                        r_state       <= S_ARM;
                        r_lives       <= LIVES_INIT;
                        r_score       <= 8'd0;
                        r_dot_respawn <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (i_hit_n) begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    // Collision wins over a simultaneous crossing.
                    if (!i_hit_n) begin
                        r_state <= S_HIT;
                        r_lives <= r_lives - 3'd1;
                    end else if (w_crossing) begin
                        r_dot_respawn <= 1'b1;
                        if (r_score != 8'hFF) begin
                            r_score <= r_score + 8'd1;
                        end
                    end
                end
                S_HIT: begin
                    if (r_lives == 3'd0) begin
                        r_state <= S_GAMEOVER;
                    end else begin
                        r_state <= S_RESPAWN;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_RESPAWN: begin
                    if (r_cnt == '0) begin
                        r_state       <= S_ARM;
                        r_dot_respawn <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_go          = (r_state == S_ARM);
    assign o_run         = (r_state == S_PLAY);
    assign o_game_over   = (r_state == S_GAMEOVER);
    assign o_dot_respawn = r_dot_respawn;
    assign o_lives       = r_lives;
    assign o_score       = r_score;

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: directed scenarios plus randomized
// play compared against a behavioural game model.
module tb_game_control;

    localparam int         LIVES          = 2;
    localparam int         RESPAWN_CYCLES = 4;
    localparam logic [6:0] WIN_Y          = 7'd0;

    logic       i_clk;
    logic       i_reset;
    logic       i_start_key;
    logic       i_hit_n;
    logic [6:0] i_y_dot;
    logic       o_go;
    logic       o_run;
    logic       o_dot_respawn;
    logic [2:0] o_lives;
    logic [7:0] o_score;
    logic       o_game_over;

    int checks   = 0;
    int failures = 0;

    game_control #(
        .LIVES         (LIVES),
        .RESPAWN_CYCLES(RESPAWN_CYCLES),
        .WIN_Y         (WIN_Y)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start_key  (i_start_key),
        .i_hit_n      (i_hit_n),
        .i_y_dot      (i_y_dot),
        .o_go         (o_go),
        .o_run        (o_run),
        .o_dot_respawn(o_dot_respawn),
        .o_lives      (o_lives),
        .o_score      (o_score),
        .o_game_over  (o_game_over)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Behavioural game model: phases of play, a countdown of frozen cycles left.
    typedef enum int {PH_WAIT, PH_REARM, PH_LIVE, PH_STRUCK, PH_FROZEN, PH_ENDED} phase_t;
    phase_t ph;
    int     m_lives;
    int     m_score;
    int     m_freeze;
    bit     m_pulse;
    bit     m_prev_start;
    bit     m_prev_top;

    task automatic model_reset();
        ph           = PH_WAIT;
        m_lives      = LIVES;
        m_score      = 0;
        m_freeze     = 0;
        m_pulse      = 1'b0;
        m_prev_start = 1'b0;
        m_prev_top   = 1'b1;
    endtask

    task automatic model_step();
        bit new_press;
        bit at_top;
        bit arrived;
        new_press = i_start_key && !m_prev_start;
        at_top    = (i_y_dot <= WIN_Y);
        arrived   = at_top && !m_prev_top;
        m_pulse   = 1'b0;
        case (ph)
            PH_WAIT, PH_ENDED: if (new_press) begin
                ph = PH_REARM; m_lives = LIVES; m_score = 0; m_pulse = 1'b1;
            end
            PH_REARM: if (i_hit_n) ph = PH_LIVE;
            PH_LIVE: begin
                if (!i_hit_n) begin
                    ph = PH_STRUCK; m_lives = m_lives - 1;
                end else if (arrived) begin
                    m_score = (m_score >= 255) ? 255 : m_score + 1;
                    m_pulse = 1'b1;
                end
            end
            PH_STRUCK: begin
                if (m_lives == 0) ph = PH_ENDED;
                else begin ph = PH_FROZEN; m_freeze = RESPAWN_CYCLES; end
            end
            PH_FROZEN: begin
                m_freeze = m_freeze - 1;
                if (m_freeze == 0) begin ph = PH_REARM; m_pulse = 1'b1; end
            end
            default: ph = PH_WAIT;
        endcase
        m_prev_start = i_start_key;
        m_prev_top   = at_top;
    endtask

    // Advance one clock; model follows the inputs present at the edge.
    task automatic tick();
        if (!i_reset) model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start_key = 1'b0; i_hit_n = 1'b1; i_y_dot = 7'd5;
        model_reset();
        #2;
        checks++; if (o_go !== 1'b0) begin failures++; $display("FAIL reset_go: got %0b expected 0", o_go); end
        checks++; if (o_run !== 1'b0) begin failures++; $display("FAIL reset_run: got %0b expected 0", o_run); end
        checks++; if (o_lives !== 3'd2) begin failures++; $display("FAIL reset_lives: got %0d expected 2", o_lives); end
        checks++; if (o_score !== 8'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", o_score); end
        checks++; if (o_game_over !== 1'b0) begin failures++; $display("FAIL reset_gameover: got %0b expected 0", o_game_over); end
        checks++; if (o_dot_respawn !== 1'b0) begin failures++; $display("FAIL reset_respawn: got %0b expected 0", o_dot_respawn); end
        tick();
        i_reset = 1'b0;
        tick();
        checks++; if (o_go !== 1'b0) begin failures++; $display("FAIL idle_go: got %0b expected 0", o_go); end
        $display("test_reset done");
    endtask

    task automatic test_start();
        i_start_key = 1'b1;
        tick();
        checks++; if (o_go !== 1'b1) begin failures++; $display("FAIL start_go: got %0b expected 1", o_go); end
        checks++; if (o_dot_respawn !== 1'b1) begin failures++; $display("FAIL start_respawn: got %0b expected 1", o_dot_respawn); end
        checks++; if (o_lives !== 3'd2) begin failures++; $display("FAIL start_lives: got %0d expected 2", o_lives); end
        tick();
        checks++; if (o_run !== 1'b1 || o_go !== 1'b0) begin failures++; $display("FAIL start_play: got run=%0b go=%0b expected run=1 go=0", o_run, o_go); end
        checks++; if (o_dot_respawn !== 1'b0) begin failures++; $display("FAIL start_pulse_width: got %0b expected 0", o_dot_respawn); end
        $display("test_start done");
    endtask

    task automatic test_collision();
        i_hit_n = 1'b0;
        tick();
        checks++; if (o_lives !== 3'd1) begin failures++; $display("FAIL hit_lives: got %0d expected 1", o_lives); end
        checks++; if (o_run !== 1'b0 || o_go !== 1'b0) begin failures++; $display("FAIL hit_outputs: got run=%0b go=%0b expected 0 0", o_run, o_go); end
        for (int i = 0; i < RESPAWN_CYCLES; i++) begin
            tick();
            checks++; if (o_run !== 1'b0 || o_go !== 1'b0) begin failures++; $display("FAIL respawn_freeze%0d: got run=%0b go=%0b expected 0 0", i, o_run, o_go); end
        end
        tick();
        checks++; if (o_go !== 1'b1) begin failures++; $display("FAIL rearm_go: got %0b expected 1", o_go); end
        checks++; if (o_dot_respawn !== 1'b1) begin failures++; $display("FAIL rearm_respawn: got %0b expected 1", o_dot_respawn); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_go !== 1'b1) begin failures++; $display("FAIL arm_hold%0d: got %0b expected 1", i, o_go); end
        end
        i_hit_n = 1'b1;
        #1;
        checks++; if (o_go !== 1'b1) begin failures++; $display("FAIL arm_release_go: got %0b expected 1", o_go); end
        tick();
        checks++; if (o_go !== 1'b0 || o_run !== 1'b1) begin failures++; $display("FAIL arm_to_play: got go=%0b run=%0b expected 0 1", o_go, o_run); end
        $display("test_collision done");
    endtask

    task automatic test_last_life();
        i_y_dot = 7'd0;
        tick();
        checks++; if (o_score !== 8'd1) begin failures++; $display("FAIL pre_score: got %0d expected 1", o_score); end
        i_y_dot = 7'd5;
        tick();
        i_hit_n = 1'b0;
        tick();
        checks++; if (o_lives !== 3'd0) begin failures++; $display("FAIL last_lives: got %0d expected 0", o_lives); end
        tick();
        checks++; if (o_game_over !== 1'b1 || o_run !== 1'b0 || o_go !== 1'b0) begin failures++; $display("FAIL gameover_outputs: got go_=%0b run=%0b go=%0b expected 1 0 0", o_game_over, o_run, o_go); end
        checks++; if (o_score !== 8'd1) begin failures++; $display("FAIL gameover_score: got %0d expected 1", o_score); end
        i_hit_n = 1'b1; i_start_key = 1'b0;
        tick();
        checks++; if (o_game_over !== 1'b1) begin failures++; $display("FAIL gameover_hold: got %0b expected 1", o_game_over); end
        i_start_key = 1'b1;
        tick();
        checks++; if (o_go !== 1'b1 || o_lives !== 3'd2 || o_score !== 8'd0) begin failures++; $display("FAIL restart: got go=%0b lives=%0d score=%0d expected 1 2 0", o_go, o_lives, o_score); end
        checks++; if (o_dot_respawn !== 1'b1) begin failures++; $display("FAIL restart_respawn: got %0b expected 1", o_dot_respawn); end
        tick();
        $display("test_last_life done");
    endtask

    task automatic test_scoring();
        int budget;
        tick();
        i_y_dot = 7'd0;
        tick();
        checks++; if (o_score !== 8'd1 || o_dot_respawn !== 1'b1) begin failures++; $display("FAIL cross_once: got score=%0d pulse=%0b expected 1 1", o_score, o_dot_respawn); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o_score !== 8'd1 || o_dot_respawn !== 1'b0) begin failures++; $display("FAIL parked%0d: got score=%0d pulse=%0b expected 1 0", i, o_score, o_dot_respawn); end
        end
        i_y_dot = 7'd5;
        tick();
        i_y_dot = 7'd0; i_hit_n = 1'b0;
        tick();
        checks++; if (o_score !== 8'd1 || o_lives !== 3'd1 || o_run !== 1'b0) begin failures++; $display("FAIL hit_priority: got score=%0d lives=%0d run=%0b expected 1 1 0", o_score, o_lives, o_run); end
        i_hit_n = 1'b1; i_y_dot = 7'd5;
        budget = 20;
        while (o_run !== 1'b1 && budget > 0) begin tick(); budget--; end
        checks++; if (o_run !== 1'b1) begin failures++; $display("FAIL return_to_play: got run=%0b expected 1", o_run); end
        $display("test_scoring done");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            i_y_dot = 7'd5;
            tick();
            i_y_dot = 7'd0;
            tick();
            if (i == 253) begin
                checks++; if (o_score !== 8'd255) begin failures++; $display("FAIL sat_reach: got %0d expected 255", o_score); end
            end
        end
        checks++; if (o_score !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", o_score); end
        checks++; if (o_dot_respawn !== 1'b1) begin failures++; $display("FAIL sat_pulse: got %0b expected 1", o_dot_respawn); end
        $display("test_saturation done");
    endtask

    task automatic test_async_reset();
        i_reset = 1'b1; model_reset();
        tick();
        i_reset = 1'b0; i_start_key = 1'b0; i_hit_n = 1'b1; i_y_dot = 7'd5;
        tick();
        i_start_key = 1'b1;
        tick();
        tick();
        i_hit_n = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (o_lives !== 3'd1) begin failures++; $display("FAIL pre_async_lives: got %0d expected 1", o_lives); end
        i_reset = 1'b1; model_reset();
        #1;
        checks++; if (o_go !== 1'b0 || o_run !== 1'b0 || o_lives !== 3'd2) begin failures++; $display("FAIL async_reset: got go=%0b run=%0b lives=%0d expected 0 0 2", o_go, o_run, o_lives); end
        #1;
        i_reset = 1'b0; i_hit_n = 1'b1; i_start_key = 1'b0;
        tick();
        checks++; if (o_go !== 1'b0 || o_run !== 1'b0) begin failures++; $display("FAIL async_idle: got go=%0b run=%0b expected 0 0", o_go, o_run); end
        i_start_key = 1'b1;
        tick();
        checks++; if (o_go !== 1'b1) begin failures++; $display("FAIL async_restart: got %0b expected 1", o_go); end
        $display("test_async_reset done");
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            i_start_key = ($urandom_range(0, 3) == 0) ? ~i_start_key : i_start_key;
            i_hit_n     = ($urandom_range(0, 9) != 0);
            i_y_dot     = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            if ($urandom_range(0, 299) == 0) begin
                i_reset = 1'b1; model_reset();
                #1;
                i_reset = 1'b0;
            end
            tick();
            checks++; if (o_go !== (ph == PH_REARM)) begin failures++; $display("FAIL rnd_go c=%0d: got %0b expected %0b", c, o_go, ph == PH_REARM); end
            checks++; if (o_run !== (ph == PH_LIVE)) begin failures++; $display("FAIL rnd_run c=%0d: got %0b expected %0b", c, o_run, ph == PH_LIVE); end
            checks++; if (o_game_over !== (ph == PH_ENDED)) begin failures++; $display("FAIL rnd_gameover c=%0d: got %0b expected %0b", c, o_game_over, ph == PH_ENDED); end
            checks++; if (o_lives !== 3'(m_lives)) begin failures++; $display("FAIL rnd_lives c=%0d: got %0d expected %0d", c, o_lives, m_lives); end
            checks++; if (o_score !== 8'(m_score)) begin failures++; $display("FAIL rnd_score c=%0d: got %0d expected %0d", c, o_score, m_score); end
            checks++; if (o_dot_respawn !== m_pulse) begin failures++; $display("FAIL rnd_respawn c=%0d: got %0b expected %0b", c, o_dot_respawn, m_pulse); end
        end
        $display("test_random done cycles=%0d", n);
    endtask

    initial begin
        test_reset();
        test_start();
        test_collision();
        test_last_life();
        test_scoring();
        test_saturation();
        test_async_reset();
        test_random(2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
